result_display: RTL and testbench
=================================

# result_display

Sequential display back-end that consumes the 8-bit arithmetic result and the overflow/decimal-point flags produced by the arithmetic unit, and drives three active-low 7-segment digits plus an overflow LED.
- Converts binary to BCD with an iterative shift-and-add-3 (double-dabble) engine, one shift per clock.
- Re-runs the conversion whenever its inputs change.
- Sits directly downstream of the arithmetic unit and directly upstream of the board HEX/LED pins.

## Interface
Parameters:
- `CONV_CYCLES`, default 8: number of shift iterations; equals the value width.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `value`, input, 8: unsigned result from the arithmetic unit (0..255).
- `add_sub_ovf`, input, 1: add/subtract carry flag.
- `mult_div_ovf`, input, 2: decimal-point flags. Bit 0 lights the hex0 dp; bit 1 lights the hex1 dp.
- `hex0`, output, 8: ones digit, active-low, bit order {dp,g,f,e,d,c,b,a}.
- `hex1`, output, 8: tens digit, same encoding.
- `hex2`, output, 8: hundreds digit, same encoding; hex2 dp is always off.
- `ovf_led`, output, 1: registered copy of `add_sub_ovf`.
- `busy`, output, 1: high while a conversion is in progress.
- `done`, output, 1: one-cycle pulse in the cycle in which the digit outputs update.

## Operation
- The FSM has three states: IDLE, CONV and UPDATE.
- Shadow register holds {value, add_sub_ovf, mult_div_ovf}.
- A `pending` flag is set by reset.
- IDLE → CONV when `pending` is set, or when the live inputs differ from the shadow. On that edge:
  - load the shadow;
  - load the shift register with {12'b0, value};
  - clear the iteration counter and clear `pending`.
- CONV, each cycle:
  - every BCD nibble ≥5 gets +3;
  - the 20-bit register then shifts left by 1;
  - the counter increments.
- CONV → UPDATE after the `CONV_CYCLES`-th shift.
- In UPDATE:
  - encode the hundreds, tens and ones digits into `hex2`, `hex1` and `hex0`;
  - apply the dp bits from the shadowed `mult_div_ovf`;
  - register `ovf_led` from the shadow;
  - pulse `done`.
- UPDATE → IDLE unconditionally.
- Inputs that change during CONV or UPDATE are ignored. The change is caught on the first IDLE cycle by the shadow compare, so the last value always wins and no update is lost.
- The hundreds digit never exceeds 2. Digit values 10–15 cannot occur; if forced, the encoder outputs blank (8'hFF).
- Segment codes (dp off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. A lit dp clears bit 7.

## Timing
- Reset values: `hex0`/`hex1`/`hex2` = 8'hFF (blank), `ovf_led` = 0, `busy` = 0, `done` = 0, state = IDLE, shadow = 0, `pending` = 1.
- Edge 0 samples the change (IDLE → CONV).
- Edges 1..8 perform the shifts; edge 8 moves CONV → UPDATE.
- Edge 9 registers the outputs, pulses `done` and returns to IDLE.
- Latency: 10 rising edges from the first edge that samples the change to visible outputs.
- `busy` is registered: high from after edge 0 until edge 9, i.e. 9 cycles.
- Minimum spacing between back-to-back updates is 10 cycles.
- Reset asserted mid-operation immediately forces all reset values. After release, the set `pending` flag starts a fresh conversion.

## Configuration
- Macro: `LEADING_ZERO_BLANK_EN`.
- Defined:
  - `hex2` is blank (8'hFF, dp off) when hundreds = 0;
  - `hex1` is blank when hundreds = 0 and tens = 0, but its dp still obeys `mult_div_ovf[1]`;
  - `hex0` is never blanked.
- Undefined: all three digits always show their numeral, including leading zeros.

## Structure
- Package `display_pkg`:
  - state enum {IDLE, CONV, UPDATE};
  - segment-code constants SEG_0..SEG_9 and SEG_BLANK;
  - BCD width constant (12).
- One sub-module, `seven_seg_encoder`: combinational, maps a 4-bit digit plus a dp bit to 8 active-low segments. Instantiated three times.

## Test plan
- Reset, `value`=0, flags 0 → after 10 cycles: `hex0`=C0, `hex1`=FF, `hex2`=FF (macro defined); `done` pulses once.
- `value`=255 → `hex2`=A4, `hex1`=92, `hex0`=92; `busy` high exactly 9 cycles; `done` coincides with the update.
- `value`=7, `mult_div_ovf`=2'b01 → `hex0`=78, `hex1`=FF; with the macro undefined, `hex1`=C0 and `hex2`=C0.
- `value`=100, then 42 presented 3 cycles later → display shows 100 (hex2=F9, hex1=C0, hex0=C0), then 42 (hex1=99, hex0=A4) exactly 10 cycles after the first `done`.
- `add_sub_ovf`=1 with `value`=16 → `ovf_led` rises on the same edge that `hex1`=F9, `hex0`=82.
- `rst_n` pulsed low during CONV → outputs go FF/0 asynchronously; after release, the conversion of the current `value` completes in 10 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the result display: FSM states, active-low
// segment codes {dp,g,f,e,d,c,b,a} and the double-dabble digit correction.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam int BCD_W = 12;
    localparam int VAL_W = 8;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // A nibble of 5 or more would exceed 9 after doubling, so pre-correct it
    function automatic logic [3:0] add3(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd5) begin
            r = d + 4'd3;
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/seven_seg_encoder.sv
// Combinational BCD digit to active-low 7-segment encoder with decimal point.
// Non-decimal digit codes produce a fully blank pattern, dp included.
module seven_seg_encoder
    import display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dp,
    output logic [7:0] seg
);

    logic [7:0] code_s;
    logic       valid_s;

    // Digit lookup; anything outside 0..9 is blanked
    always_comb begin
        code_s  = SEG_BLANK;
        valid_s = 1'b1;
        case (digit)
            4'd0:    code_s = SEG_0;
            4'd1:    code_s = SEG_1;
            4'd2:    code_s = SEG_2;
            4'd3:    code_s = SEG_3;
            4'd4:    code_s = SEG_4;
            4'd5:    code_s = SEG_5;
            4'd6:    code_s = SEG_6;
            4'd7:    code_s = SEG_7;
            4'd8:    code_s = SEG_8;
            4'd9:    code_s = SEG_9;
            default: begin
                code_s  = SEG_BLANK;
                valid_s = 1'b0;
            end
        endcase
    end

    assign seg = {code_s[7] & ~(dp & valid_s), code_s[6:0]};

endmodule

// File: rtl/result_display.sv
// Result display back-end: shadows the arithmetic result, converts it to BCD by
// iterative double-dabble and drives three registered 7-segment digits.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module result_display
    import display_pkg::*;
#(
    parameter int CONV_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] value,
    input  logic       add_sub_ovf,
    input  logic [1:0] mult_div_ovf,
    output logic [7:0] hex0,
    output logic [7:0] hex1,
    output logic [7:0] hex2,
    output logic       ovf_led,
    output logic       busy,
    output logic       done
);

    localparam int SHIFT_W = BCD_W + VAL_W;
    localparam int CNT_W   = $clog2(CONV_CYCLES + 1);

    state_t               state_r, state_s;
    logic [10:0]          shadow_r;
    logic [10:0]          live_s;
    logic                 pending_r;
    logic [SHIFT_W-1:0]   shift_r;
    logic [SHIFT_W-1:0]   dabbled_s;
    logic [CNT_W-1:0]     cnt_r;
    logic                 start_s;
    logic                 last_s;
    logic [3:0]           ones_s, tens_s, hund_s;
    logic [7:0]           seg0_s, seg1_s, seg2_s;
    logic [7:0]           hex1_next_s, hex2_next_s;
    logic                 blank1_s, blank2_s;
    logic [7:0]           hex0_r, hex1_r, hex2_r;
    logic                 ovf_led_r, busy_r, done_r;

    // Shadow layout: {value, add_sub_ovf, mult_div_ovf}
    assign live_s  = {value, add_sub_ovf, mult_div_ovf};
    assign start_s = (state_r == IDLE) && (pending_r || (live_s != shadow_r));
    assign last_s  = (cnt_r == CNT_W'(CONV_CYCLES - 1));

    assign ones_s = shift_r[VAL_W     +: 4];
    assign tens_s = shift_r[VAL_W + 4 +: 4];
    assign hund_s = shift_r[VAL_W + 8 +: 4];

    assign dabbled_s = {add3(hund_s), add3(tens_s), add3(ones_s), shift_r[VAL_W-1:0]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) state_s = CONV;
                else         state_s = IDLE;
            end
            CONV: begin
                if (last_s) state_s = UPDATE;
                else        state_s = CONV;
            end
            UPDATE:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    seven_seg_encoder u_enc0 (.digit(ones_s), .dp(shadow_r[0]), .seg(seg0_s));
    seven_seg_encoder u_enc1 (.digit(tens_s), .dp(shadow_r[1]), .seg(seg1_s));
    seven_seg_encoder u_enc2 (.digit(hund_s), .dp(1'b0),        .seg(seg2_s));

    // Leading-zero suppression; a blanked tens digit keeps its decimal point
    always_comb begin
        blank1_s = 1'b0;
        blank2_s = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blank2_s = (hund_s == 4'd0);
        blank1_s = (hund_s == 4'd0) && (tens_s == 4'd0);
`else
        blank2_s = 1'b0;
        blank1_s = 1'b0;
`endif
        if (blank2_s) hex2_next_s = SEG_BLANK;
        else          hex2_next_s = seg2_s;
        if (blank1_s) hex1_next_s = {~shadow_r[1], 7'h7F};
        else          hex1_next_s = seg1_s;
    end

    // Shadow capture, conversion datapath and registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r  <= 11'd0;
            pending_r <= 1'b1;
            shift_r   <= '0;
            cnt_r     <= '0;
            hex0_r    <= SEG_BLANK;
            hex1_r    <= SEG_BLANK;
            hex2_r    <= SEG_BLANK;
            ovf_led_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        shadow_r  <= live_s;
                        shift_r   <= {{BCD_W{1'b0}}, value};
                        cnt_r     <= '0;
                        pending_r <= 1'b0;
                        busy_r    <= 1'b1;
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end
                CONV: begin
                    shift_r <= {dabbled_s[SHIFT_W-2:0], 1'b0};
                    cnt_r   <= cnt_r + CNT_W'(1);
                end
                UPDATE: begin
                    hex0_r    <= seg0_s;
                    hex1_r    <= hex1_next_s;
                    hex2_r    <= hex2_next_s;
                    ovf_led_r <= shadow_r[2];
                    done_r    <= 1'b1;
                    busy_r    <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign hex0    = hex0_r;
    assign hex1    = hex1_r;
    assign hex2    = hex2_r;
    assign ovf_led = ovf_led_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_result_display.sv
// Directed self-checking bench for result_display; expected segment patterns
// are hand-computed, with leading-zero variants selected by the build macro.
module tb_result_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] value;
    logic       add_sub_ovf;
    logic [1:0] mult_div_ovf;
    logic [7:0] hex0, hex1, hex2;
    logic       ovf_led, busy, done;

    int total = 0;
    int bad   = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic blank_en = 1'b1;
`else
    localparam logic blank_en = 1'b0;
`endif

    result_display #(.CONV_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .add_sub_ovf(add_sub_ovf),
        .mult_div_ovf(mult_div_ovf), .hex0(hex0), .hex1(hex1), .hex2(hex2),
        .ovf_led(ovf_led), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    // Counts negedges until done (bounded), busy-high samples, and ovf_led just before done
    task automatic wait_update(output int n, output int nb, output logic ovf_prev);
        n = 0;
        nb = 0;
        ovf_prev = 1'b0;
        for (int k = 0; k < 30; k++) begin
            ovf_prev = ovf_led;
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (done) break;
        end
    endtask

    typedef struct {
        logic [7:0] v;
        logic [7:0] h2;
        logic [7:0] h1;
        logic [7:0] h0;
        logic       h2_lz;
        logic       h1_lz;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n, nb;
        logic op;

        vecs[0] = '{8'd9,   8'hC0, 8'hC0, 8'h90, 1'b1, 1'b1};
        vecs[1] = '{8'd10,  8'hC0, 8'hF9, 8'hC0, 1'b1, 1'b0};
        vecs[2] = '{8'd99,  8'hC0, 8'h90, 8'h90, 1'b1, 1'b0};
        vecs[3] = '{8'd128, 8'hF9, 8'hA4, 8'h80, 1'b0, 1'b0};
        vecs[4] = '{8'd199, 8'hF9, 8'h90, 8'h90, 1'b0, 1'b0};

        rst_n = 1'b0;
        value = 8'd0;
        add_sub_ovf = 1'b0;
        mult_div_ovf = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("rst_hex0", hex0, 8'hFF);
        chk("rst_hex1", hex1, 8'hFF);
        chk("rst_hex2", hex2, 8'hFF);
        chk("rst_ovf",  ovf_led, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);

        // Pending after reset: zero converts without any input change
        rst_n = 1'b1;
        wait_update(n, nb, op);
        chk("zero_lat",  n, 10);
        chk("zero_busy", nb, 9);
        chk("zero_hex0", hex0, 8'hC0);
        chk("zero_hex1", hex1, blank_en ? 8'hFF : 8'hC0);
        chk("zero_hex2", hex2, blank_en ? 8'hFF : 8'hC0);
        @(negedge clk);
        chk("zero_done_pulse", done, 1'b0);
        @(negedge clk);
        chk("zero_idle_busy", busy, 1'b0);

        value = 8'd255;
        wait_update(n, nb, op);
        chk("v255_lat",  n, 10);
        chk("v255_busy", nb, 9);
        chk("v255_hex2", hex2, 8'hA4);
        chk("v255_hex1", hex1, 8'h92);
        chk("v255_hex0", hex0, 8'h92);

        value = 8'd7;
        mult_div_ovf = 2'b01;
        wait_update(n, nb, op);
        chk("v7_lat",  n, 10);
        chk("v7_hex0", hex0, 8'h78);
        chk("v7_hex1", hex1, blank_en ? 8'hFF : 8'hC0);
        chk("v7_hex2", hex2, blank_en ? 8'hFF : 8'hC0);

        // Blanked tens digit still shows its dp
        value = 8'd3;
        mult_div_ovf = 2'b10;
        wait_update(n, nb, op);
        chk("v3_hex0", hex0, 8'hB0);
        chk("v3_hex1", hex1, blank_en ? 8'h7F : 8'h40);

        // Change during conversion is picked up right after the first update
        value = 8'd100;
        mult_div_ovf = 2'b00;
        repeat (3) @(negedge clk);
        value = 8'd42;
        wait_update(n, nb, op);
        chk("v100_lat",  n, 7);
        chk("v100_hex2", hex2, 8'hF9);
        chk("v100_hex1", hex1, 8'hC0);
        chk("v100_hex0", hex0, 8'hC0);
        wait_update(n, nb, op);
        chk("v42_lat",  n, 10);
        chk("v42_hex1", hex1, 8'h99);
        chk("v42_hex0", hex0, 8'hA4);
        chk("v42_hex2", hex2, blank_en ? 8'hFF : 8'hC0);

        for (int i = 0; i < 5; i++) begin
            value = vecs[i].v;
            wait_update(n, nb, op);
            chk($sformatf("tbl%0d_lat", i), n, 10);
            chk($sformatf("tbl%0d_hex2", i), hex2, (blank_en && vecs[i].h2_lz) ? 8'hFF : vecs[i].h2);
            chk($sformatf("tbl%0d_hex1", i), hex1, (blank_en && vecs[i].h1_lz) ? 8'hFF : vecs[i].h1);
            chk($sformatf("tbl%0d_hex0", i), hex0, vecs[i].h0);
        end

        value = 8'd16;
        add_sub_ovf = 1'b1;
        wait_update(n, nb, op);
        chk("ovf_before", op, 1'b0);
        chk("ovf_led",    ovf_led, 1'b1);
        chk("v16_hex1",   hex1, 8'hF9);
        chk("v16_hex0",   hex0, 8'h82);

        // Asynchronous reset in the middle of a conversion
        value = 8'd200;
        add_sub_ovf = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_hex0", hex0, 8'hFF);
        chk("arst_hex1", hex1, 8'hFF);
        chk("arst_hex2", hex2, 8'hFF);
        chk("arst_ovf",  ovf_led, 1'b0);
        chk("arst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_update(n, nb, op);
        chk("v200_lat",  n, 10);
        chk("v200_busy", nb, 9);
        chk("v200_hex2", hex2, 8'hA4);
        chk("v200_hex1", hex1, 8'hC0);
        chk("v200_hex0", hex0, 8'hC0);
        chk("v200_ovf",  ovf_led, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
